// File: rtl/dispctrl_seq_pkg.sv
// Shared definitions for the dispctrl frame-update sequencer: state encoding,
// LCD opcodes and the window-setup command ROM.
package dispctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_SETTLE,
    ST_SCAN,
    ST_DRAIN
  } seq_state_t;

  localparam logic [7:0] LCD_CASET = 8'h2a;
  localparam logic [7:0] LCD_RASET = 8'h2b;
  localparam logic [7:0] LCD_RAMWR = 8'h2c;

  localparam int         N_CMD_STEPS = 11;
  localparam logic [3:0] LAST_STEP   = 4'(N_CMD_STEPS - 1);

  // Opcode steps go out with DC low; coordinate bytes with DC high.
  function automatic logic cmd_dc(input logic [3:0] step);
    case (step)
      4'd0, 4'd5, 4'd10: cmd_dc = 1'b0;
      default:           cmd_dc = 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] cmd_byte(
    input logic [3:0]  step,
    input logic [15:0] x0,
    input logic [15:0] x1,
    input logic [15:0] y0,
    input logic [15:0] y1
  );
    case (step)
      4'd0:    cmd_byte = LCD_CASET;
      4'd1:    cmd_byte = x0[15:8];
      4'd2:    cmd_byte = x0[7:0];
      4'd3:    cmd_byte = x1[15:8];
      4'd4:    cmd_byte = x1[7:0];
      4'd5:    cmd_byte = LCD_RASET;
      4'd6:    cmd_byte = y0[15:8];
      4'd7:    cmd_byte = y0[7:0];
      4'd8:    cmd_byte = y1[15:8];
      4'd9:    cmd_byte = y1[7:0];
      default: cmd_byte = LCD_RAMWR;
    endcase
  endfunction

endpackage

// File: rtl/dispctrl_seq_idle_wait.sv
// Guard timer plus tx_busy qualifier: idle_ok once SYNC_GUARD cycles have
// elapsed since arm and the synced shifter-busy flag is low.
module dispctrl_seq_idle_wait #(
  parameter int SYNC_GUARD = 4
) (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic arm,
  input  logic tx_busy,
  output logic idle_ok
);

  localparam int W_CNT = (SYNC_GUARD > 0) ? $clog2(SYNC_GUARD + 1) : 1;

  logic [W_CNT-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (rst_sys)
      cnt <= '0;
    else if (arm)
      cnt <= W_CNT'(SYNC_GUARD);
    else if (cnt != '0)
      cnt <= cnt - W_CNT'(1);
  end

  // tx_busy is only meaningful once FIFO-empty and busy syncs have caught up.
  assign idle_ok = (cnt == '0) && !tx_busy;

endmodule

// File: rtl/riscboy_ppu_dispctrl_seq.sv
// Frame-update sequencer: pushes LCD window setup commands, runs scan-out for
// a programmed number of scanbufs, drains, and hands LCD control back to CSRs.
module riscboy_ppu_dispctrl_seq
  import dispctrl_seq_pkg::*;
#(
  parameter int W_COORD    = 9,
  parameter int W_NBUF     = 9,
  parameter int SYNC_GUARD = 4
) (
  input  logic               clk_sys,
  input  logic               rst_sys,
  input  logic               start,
  input  logic               abort,
  input  logic [W_COORD-1:0] win_x0,
  input  logic [W_COORD-1:0] win_x1,
  input  logic [W_COORD-1:0] win_y0,
  input  logic [W_COORD-1:0] win_y1,
  input  logic [W_NBUF-1:0]  frame_bufs,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  input  logic               sw_scan_en,
  input  logic               sw_lcd_cs,
  input  logic               sw_lcd_dc,
  input  logic               sw_shiftcnt,
  output logic               scan_en,
  output logic               lcd_cs,
  output logic               lcd_dc,
  output logic               lcd_shiftcnt,
  output logic [15:0]        pxfifo_wdata,
  output logic               pxfifo_wen,
  input  logic               pxfifo_full,
  input  logic               tx_busy,
  input  logic               scanout_buf_release
);

  seq_state_t state, state_nxt;

  logic [W_COORD-1:0] x0_r, x1_r, y0_r, y1_r;
  logic [W_NBUF-1:0]  nbuf_r, rel_cnt;
  logic [W_NBUF:0]    rel_next;
  logic [3:0]         step;
  logic               dc_r, next_dc, to_scan, shift_r;
  logic               push, arm, idle_ok, accept, last_rel, step_dc_flip;
  logic [7:0]         cur_byte;

  assign accept       = (state == ST_IDLE) && start && !abort;
  assign cur_byte     = cmd_byte(step, 16'(x0_r), 16'(x1_r), 16'(y0_r), 16'(y1_r));
  assign step_dc_flip = cmd_dc(step + 4'd1) != dc_r;
  assign rel_next     = {1'b0, rel_cnt} + (W_NBUF+1)'(1);
  assign last_rel     = rel_next == {1'b0, nbuf_r};

  always_ff @(posedge clk_sys) begin
    if (rst_sys)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    unique case (state)
      ST_IDLE:   if (accept) state_nxt = ST_CMD;
      ST_CMD: begin
        // abort wins over a push presented in the same cycle
        if (abort)
          state_nxt = ST_DRAIN;
        else if (!pxfifo_full) begin
          push = 1'b1;
          if (step == LAST_STEP || step_dc_flip)
            state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort)
          state_nxt = ST_DRAIN;
        else if (idle_ok)
          state_nxt = !to_scan ? ST_CMD : (nbuf_r == '0 ? ST_DRAIN : ST_SCAN);
      end
      ST_SCAN: begin
        if (abort || (scanout_buf_release && last_rel))
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN:  if (idle_ok) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Restart the guard on every entry into a waiting state.
  assign arm = (state_nxt != state) && (state_nxt == ST_SETTLE || state_nxt == ST_DRAIN);

  dispctrl_seq_idle_wait #(.SYNC_GUARD(SYNC_GUARD)) u_idle_wait (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .arm     (arm),
    .tx_busy (tx_busy),
    .idle_ok (idle_ok)
  );

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      x0_r    <= '0;
      x1_r    <= '0;
      y0_r    <= '0;
      y1_r    <= '0;
      nbuf_r  <= '0;
      rel_cnt <= '0;
      step    <= '0;
      dc_r    <= 1'b0;
      next_dc <= 1'b0;
      to_scan <= 1'b0;
      shift_r <= 1'b0;
      aborted <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == ST_DRAIN) && idle_ok;
      case (state)
        ST_IDLE: if (accept) begin
          x0_r    <= win_x0;
          x1_r    <= win_x1;
          y0_r    <= win_y0;
          y1_r    <= win_y1;
          nbuf_r  <= frame_bufs;
          rel_cnt <= '0;
          step    <= '0;
          dc_r    <= 1'b0;
          to_scan <= 1'b0;
          shift_r <= 1'b0;
          aborted <= 1'b0;
        end
        ST_CMD: begin
          if (abort)
            aborted <= 1'b1;
          else if (push) begin
            if (step == LAST_STEP) begin
              next_dc <= 1'b1;
              to_scan <= 1'b1;
            end else if (step_dc_flip)
              next_dc <= cmd_dc(step + 4'd1);
            else
              step <= step + 4'd1;
          end
        end
        ST_SETTLE: begin
          if (abort)
            aborted <= 1'b1;
          else if (idle_ok) begin
            // DC only moves here, after the shifter has gone quiet.
            dc_r <= next_dc;
            if (!to_scan)
              step <= step + 4'd1;
            else if (nbuf_r != '0)
              shift_r <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (abort)
            aborted <= 1'b1;
          else if (scanout_buf_release)
            rel_cnt <= rel_next[W_NBUF-1:0];
        end
        ST_DRAIN: if (abort) aborted <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy         = state != ST_IDLE;
  assign lcd_cs       = busy ? 1'b0 : sw_lcd_cs;
  assign lcd_dc       = busy ? dc_r : sw_lcd_dc;
  assign lcd_shiftcnt = busy ? shift_r : sw_shiftcnt;
  assign scan_en      = busy ? (state == ST_SCAN) : sw_scan_en;
  assign pxfifo_wen   = push;
  assign pxfifo_wdata = {cur_byte, 8'h00};

endmodule

// File: tb/tb_riscboy_ppu_dispctrl_seq.sv
// Randomized directed bench for the dispctrl frame sequencer, checked against
// an expected command list built from the window and frame rules.
module tb_riscboy_ppu_dispctrl_seq;

  logic       clk_sys = 1'b0;
  logic       rst_sys, start, abort;
  logic [8:0] win_x0, win_x1, win_y0, win_y1, frame_bufs;
  logic       busy, done, aborted;
  logic       sw_scan_en, sw_lcd_cs, sw_lcd_dc, sw_shiftcnt;
  logic       scan_en, lcd_cs, lcd_dc, lcd_shiftcnt;
  logic [15:0] pxfifo_wdata;
  logic       pxfifo_wen, pxfifo_full, tx_busy, scanout_buf_release;

  riscboy_ppu_dispctrl_seq #(.W_COORD(9), .W_NBUF(9), .SYNC_GUARD(4)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start), .abort(abort),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .frame_bufs(frame_bufs), .busy(busy), .done(done), .aborted(aborted),
    .sw_scan_en(sw_scan_en), .sw_lcd_cs(sw_lcd_cs), .sw_lcd_dc(sw_lcd_dc),
    .sw_shiftcnt(sw_shiftcnt), .scan_en(scan_en), .lcd_cs(lcd_cs),
    .lcd_dc(lcd_dc), .lcd_shiftcnt(lcd_shiftcnt), .pxfifo_wdata(pxfifo_wdata),
    .pxfifo_wen(pxfifo_wen), .pxfifo_full(pxfifo_full), .tx_busy(tx_busy),
    .scanout_buf_release(scanout_buf_release)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0, bad = 0;
  logic [16:0] push_q[$];
  int full_viol = 0, dc_viol = 0, cs_viol = 0, shift_viol = 0;
  int done_cnt = 0, scan_hi_cnt = 0;
  logic prev_dc = 1'b0, prev_tx = 1'b0, prev_busy = 1'b0;

  // Observe pushes and protocol rules at the inactive edge.
  always @(negedge clk_sys) begin
    if (pxfifo_wen) begin
      push_q.push_back({lcd_dc, pxfifo_wdata});
      if (pxfifo_full) full_viol <= full_viol + 1;
      if (lcd_shiftcnt) shift_viol <= shift_viol + 1;
    end
    if (busy && prev_busy && prev_tx && (lcd_dc !== prev_dc)) dc_viol <= dc_viol + 1;
    if (busy && lcd_cs) cs_viol <= cs_viol + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy && scan_en) scan_hi_cnt <= scan_hi_cnt + 1;
    prev_dc   <= lcd_dc;
    prev_tx   <= tx_busy;
    prev_busy <= busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  // Expected {dc, wdata} for command number i of a window.
  function automatic logic [16:0] exp_push(input int i, input logic [8:0] x0, x1, y0, y1);
    logic [15:0] w[4];
    logic [15:0] v;
    int k;
    w[0] = {7'd0, x0}; w[1] = {7'd0, x1}; w[2] = {7'd0, y0}; w[3] = {7'd0, y1};
    if (i == 0)  return {1'b0, 8'h2A, 8'h00};
    if (i == 5)  return {1'b0, 8'h2B, 8'h00};
    if (i == 10) return {1'b0, 8'h2C, 8'h00};
    k = (i < 5) ? i - 1 : i - 2;
    v = w[k/2];
    return (k % 2 == 0) ? {1'b1, v[15:8], 8'h00} : {1'b1, v[7:0], 8'h00};
  endfunction

  task automatic check_pushes(input string tag, input logic [8:0] x0, x1, y0, y1);
    chk({tag, "_count"}, push_q.size(), 11);
    for (int i = 0; i < 11 && i < push_q.size(); i++)
      chk({tag, "_push"}, {15'd0, push_q[i]}, {15'd0, exp_push(i, x0, x1, y0, y1)});
  endtask

  task automatic rand_sw();
    sw_scan_en  = 1'($urandom_range(0, 1));
    sw_lcd_dc   = 1'($urandom_range(0, 1));
    sw_shiftcnt = 1'($urandom_range(0, 1));
    sw_lcd_cs   = 1'b1;
  endtask

  task automatic start_frame(input logic [8:0] x0, x1, y0, y1, input int nb);
    win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1;
    frame_bufs = 9'(nb);
    push_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_scan(input string tag);
    int cyc;
    for (cyc = 0; cyc < 600; cyc++) begin
      pxfifo_full = ($urandom_range(0, 3) == 0);
      tx_busy     = 1'($urandom_range(0, 1));
      @(negedge clk_sys);
      if (busy && scan_en) break;
      tick();
    end
    chk({tag, "_scan_entry"}, 32'(cyc < 600), 1);
    chk({tag, "_scan_dc"}, lcd_dc, 1);
    chk({tag, "_scan_shift"}, lcd_shiftcnt, 1);
    chk({tag, "_scan_cs"}, lcd_cs, 0);
    tick();
    pxfifo_full = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_ab);
    int cyc, d0;
    d0 = done_cnt;
    for (cyc = 0; cyc < 600; cyc++) begin
      tx_busy     = (cyc < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
      pxfifo_full = ($urandom_range(0, 3) == 0);
      @(negedge clk_sys);
      if (done) break;
      tick();
    end
    chk({tag, "_done_seen"}, 32'(cyc < 600), 1);
    chk({tag, "_aborted"}, aborted, exp_ab);
    chk({tag, "_idle_cs"}, lcd_cs, sw_lcd_cs);
    tick();
    tx_busy = 1'b0; pxfifo_full = 1'b0;
    repeat (2) tick();
    chk({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  task automatic finish_frame(input string tag, input logic [8:0] x0, x1, y0, y1,
                              input int nb, input int max_gap);
    int sen_bad, s0;
    s0 = scan_hi_cnt;
    if (nb != 0) begin
      wait_scan(tag);
      check_pushes(tag, x0, x1, y0, y1);
      sen_bad = 0;
      for (int r = 0; r < nb; r++) begin
        repeat ($urandom_range(0, max_gap)) begin
          tx_busy = 1'($urandom_range(0, 1));
          @(negedge clk_sys);
          if (!scan_en) sen_bad++;
          tick();
        end
        scanout_buf_release = 1'b1;
        @(negedge clk_sys);
        if (!scan_en) sen_bad++;
        tick();
        scanout_buf_release = 1'b0;
      end
      @(negedge clk_sys);
      chk({tag, "_scan_en_drop"}, scan_en, 0);
      chk({tag, "_scan_en_held"}, sen_bad, 0);
      tick();
    end
    wait_done(tag, 1'b0);
    if (nb == 0) begin
      check_pushes(tag, x0, x1, y0, y1);
      chk({tag, "_no_scan"}, scan_hi_cnt - s0, 0);
    end
  endtask

  initial begin
    int n0;
    logic [8:0] rx0, rx1, ry0, ry1;
    int rnb;
    rst_sys = 1'b1; start = 1'b0; abort = 1'b0;
    win_x0 = '0; win_x1 = '0; win_y0 = '0; win_y1 = '0; frame_bufs = '0;
    pxfifo_full = 1'b0; tx_busy = 1'b0; scanout_buf_release = 1'b0;
    rand_sw();
    repeat (2) tick();
    @(negedge clk_sys);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_wen", pxfifo_wen, 0);
    chk("rst_outs", {scan_en, lcd_cs, lcd_dc, lcd_shiftcnt},
        {sw_scan_en, sw_lcd_cs, sw_lcd_dc, sw_shiftcnt});
    tick();
    rst_sys = 1'b0;
    tick();

    // Full 240x320 frame
    start_frame(9'd0, 9'd239, 9'd0, 9'd319, 320);
    finish_frame("qvga", 9'd0, 9'd239, 9'd0, 9'd319, 320, 2);

    // FIFO full held across step 2
    tx_busy = 1'b1;
    start_frame(9'd300, 9'd17, 9'd258, 9'd1, 2);
    for (int c = 0; c < 50 && push_q.size() < 1; c++) tick();
    pxfifo_full = 1'b1; tx_busy = 1'b0;
    repeat (8) tick();
    pxfifo_full = 1'b0;
    tick();
    pxfifo_full = 1'b1;
    @(negedge clk_sys);
    chk("full_step1", push_q.size(), 2);
    repeat (10) tick();
    @(negedge clk_sys);
    chk("full_hold", push_q.size(), 2);
    tick();
    pxfifo_full = 1'b0;
    finish_frame("full", 9'd300, 9'd17, 9'd258, 9'd1, 2, 1);

    // Abort in SCAN after 5 releases; start while busy is ignored
    start_frame(9'd10, 9'd100, 9'd20, 9'd200, 20);
    wait_scan("ab");
    check_pushes("ab", 9'd10, 9'd100, 9'd20, 9'd200);
    win_x0 = 9'd77; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk_sys);
    chk("start_busy_ignored", {busy, scan_en}, 2'b11);
    tick();
    repeat (5) begin
      scanout_buf_release = 1'b1; tick(); scanout_buf_release = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk_sys);
    chk("abort_scan_en", scan_en, 0);
    tick();
    wait_done("ab", 1'b1);
    chk("abort_no_push", push_q.size(), 11);
    start_frame(9'd1, 9'd2, 9'd3, 9'd4, 3);
    @(negedge clk_sys);
    chk("start_clears_aborted", aborted, 0);
    tick();
    finish_frame("after_ab", 9'd1, 9'd2, 9'd3, 9'd4, 3, 1);

    // Abort in CMD while a push is presented
    pxfifo_full = 1'b0; tx_busy = 1'b0;
    start_frame(9'd5, 9'd6, 9'd7, 9'd8, 4);
    abort = 1'b1;
    @(negedge clk_sys);
    chk("abort_cmd_drop", pxfifo_wen, 0);
    tick();
    abort = 1'b0;
    wait_done("abcmd", 1'b1);
    chk("abort_cmd_pushes", push_q.size(), 0);

    // frame_bufs == 0 skips SCAN
    start_frame(9'd511, 9'd256, 9'd128, 9'd255, 0);
    finish_frame("nb0", 9'd511, 9'd256, 9'd128, 9'd255, 0, 0);

    // start with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk_sys);
    chk("start_abort_idle", busy, 0);
    tick();

    // Synchronous reset mid-CMD
    pxfifo_full = 1'b1;
    start_frame(9'd9, 9'd9, 9'd9, 9'd9, 1);
    tick();
    rst_sys = 1'b1;
    rand_sw();
    tick();
    @(negedge clk_sys);
    chk("rst_mid_busy", {busy, pxfifo_wen}, 2'b00);
    chk("rst_mid_outs", {scan_en, lcd_cs, lcd_dc, lcd_shiftcnt},
        {sw_scan_en, sw_lcd_cs, sw_lcd_dc, sw_shiftcnt});
    tick();
    rst_sys = 1'b0; pxfifo_full = 1'b0;
    tick();

    // Random windows and lengths
    for (int f = 0; f < 4; f++) begin
      rx0 = 9'($urandom_range(0, 511)); rx1 = 9'($urandom_range(0, 511));
      ry0 = 9'($urandom_range(0, 511)); ry1 = 9'($urandom_range(0, 511));
      rnb = $urandom_range(1, 8);
      rand_sw();
      start_frame(rx0, rx1, ry0, ry1, rnb);
      finish_frame("rand", rx0, rx1, ry0, ry1, rnb, 2);
    end

    n0 = 0;
    chk("no_push_when_full", full_viol, n0);
    chk("no_dc_edge_while_busy", dc_viol, n0);
    chk("cs_low_while_busy", cs_viol, n0);
    chk("cmd_shift_8bit", shift_viol, n0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
